// File: rtl/sdtx_sequencer_pkg.sv
// sdtx_sequencer_pkg: shared state encoding, error codes and CRC-status tokens
package sdtx_sequencer_pkg;
  localparam int DW = 32;
  typedef enum logic [2:0] {IDLE, DATA, DRAIN, STATUS, BUSY} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'b00, ERR_CRC = 2'b01, ERR_WRITE = 2'b10, ERR_TIMEOUT = 2'b11} err_t;
  localparam logic [2:0] TOK_OK = 3'b010;
  localparam logic [2:0] TOK_CRC = 3'b101;
  localparam logic [2:0] TOK_WRITE = 3'b110;
endpackage

// File: rtl/sdtx_sequencer_if.sv
// sdtx_sequencer_if: memory-side and framer-side word streams
interface sdtx_sequencer_if;
  import sdtx_sequencer_pkg::*;
  logic M_VALID, M_READY, S_VALID, S_READY, S_LAST;
  logic [DW-1:0] M_DATA, S_DATA;
  modport master(input M_VALID, M_DATA, S_READY, output M_READY, S_VALID, S_DATA, S_LAST);
  modport slave(output M_VALID, M_DATA, S_READY, input M_READY, S_VALID, S_DATA, S_LAST);
endinterface

// File: rtl/sdtx_sequencer_sdtimeout.sv
// sdtimeout: loadable down-counter advanced by the card-clock strobe, flags expiry on the tick after reaching zero
module sdtimeout #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_ckstb,
  output logic         o_expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_load ? i_load_val : (i_ckstb && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge i_clk) cnt_q <= i_reset ? '0 : cnt_d;
  assign o_expired = !i_load && i_ckstb && cnt_q == '0;
endmodule

// File: rtl/sdtx_sequencer.sv
// sdtx_sequencer: multi-block SD write sequencer (stream words, await CRC status and card busy)
module sdtx_sequencer
  import sdtx_sequencer_pkg::*;
#(
  parameter int LGBLK = 9,
  parameter int LGTIMEOUT = 20,
  parameter int LGSTATUS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [15:0]             i_nblocks,
  input  logic                    i_abort,
  input  logic                    i_ckstb,
  sdtx_sequencer_if.master        bus,
  output logic                    o_tx_en,
  input  logic                    i_tx_busy,
  input  logic                    i_crcstat_valid,
  input  logic [2:0]              i_crcstat,
  input  logic                    i_dat0,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [1:0]              o_errcode
);
  localparam int WW = LGBLK - 2;
  state_t state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [15:0] blk_q, blk_d;
  logic done_q, done_d, err_q, err_d;
  err_t code_q, code_d, fail_code;
  logic xfer, fail, stat_exp, busy_exp;
  assign bus.S_VALID = state_q == DATA && bus.M_VALID && !i_abort;
  assign bus.M_READY = state_q == DATA && bus.S_READY && !i_abort;
  assign bus.S_DATA = bus.M_DATA;
  assign bus.S_LAST = state_q == DATA && word_q == '1;
  assign xfer = bus.S_VALID && bus.S_READY;
  sdtimeout #(.W(LGSTATUS)) u_stat (
    .i_clk, .i_reset, .i_load(state_q != STATUS), .i_load_val('1), .i_ckstb, .o_expired(stat_exp)
  );
  sdtimeout #(.W(LGTIMEOUT)) u_busy (
    .i_clk, .i_reset, .i_load(state_q != BUSY), .i_load_val({{(LGTIMEOUT-1){1'b1}}, 1'b0}), .i_ckstb,
    .o_expired(busy_exp)
  );
  always_comb begin
    state_d = state_q;
    word_d = xfer ? word_q + WW'(1) : word_q;
    blk_d = blk_q;
    done_d = 1'b0;
    err_d = err_q;
    code_d = code_q;
    fail = 1'b0;
    fail_code = ERR_TIMEOUT;
    case (state_q)
      IDLE: if (i_start) begin
        blk_d = i_nblocks;
        word_d = '0;
        err_d = 1'b0;
        code_d = ERR_NONE;
        state_d = i_nblocks == '0 ? IDLE : DATA;
        done_d = i_nblocks == '0;
      end
      DATA: if (xfer && word_q == '1) state_d = DRAIN;
      DRAIN: if (!i_tx_busy) state_d = STATUS;
      STATUS: if (i_crcstat_valid) begin
        state_d = i_crcstat == TOK_OK ? BUSY : STATUS;
        fail = i_crcstat != TOK_OK;
        fail_code = i_crcstat == TOK_CRC ? ERR_CRC : ERR_WRITE;
      end else fail = stat_exp;
      BUSY: if (i_ckstb && i_dat0) begin
        blk_d = blk_q - 16'd1;
        state_d = blk_q == 16'd1 ? IDLE : DATA;
        done_d = blk_q == 16'd1;
      end else fail = busy_exp;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (i_abort || fail)) begin
      state_d = IDLE;
      done_d = 1'b1;
      err_d = 1'b1;
      code_d = i_abort ? ERR_TIMEOUT : fail_code;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      word_q <= '0;
      blk_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      blk_q <= blk_d;
      done_q <= done_d;
      err_q <= err_d;
      code_q <= code_d;
    end
  end
  assign o_busy = state_q != IDLE;
  assign o_tx_en = state_q == DATA || state_q == DRAIN;
  assign o_done = done_q;
  assign o_err = err_q;
  assign o_errcode = code_q;
endmodule

// File: tb/tb_sdtx_sequencer.sv
// tb_sdtx_sequencer: directed self-checking bench for the multi-block write sequencer
module tb_sdtx_sequencer;
  localparam logic [31:0] BASE = 32'hA5C3_0000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, ckstb = 1'b1;
  logic tx_busy = 1'b0, tv = 1'b0, dat0 = 1'b1;
  logic [2:0] tok = 3'b010;
  logic [15:0] nblocks = '0;
  logic tx_en, busy, done, err;
  logic [1:0] errcode;
  int ntest = 0, nfail = 0;
  int src = 0, rcv = 0, nlast = 0, ndone = 0, nwait = 0, nsv = 0, cyc = 0, pat = 0;
  sdtx_sequencer_if ifc();
  always #5 clk = ~clk;
  assign ifc.M_DATA = BASE + 32'(src);
  sdtx_sequencer #(.LGBLK(4), .LGTIMEOUT(8), .LGSTATUS(6)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_nblocks(nblocks), .i_abort(abort),
    .i_ckstb(ckstb), .bus(ifc), .o_tx_en(tx_en), .i_tx_busy(tx_busy), .i_crcstat_valid(tv),
    .i_crcstat(tok), .i_dat0(dat0), .o_busy(busy), .o_done(done), .o_err(err), .o_errcode(errcode)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic hs_m;
    @(negedge clk);
    hs_m = ifc.M_VALID && ifc.M_READY;
    if (ifc.S_VALID && ifc.S_READY) begin
      chk("s_data", ifc.S_DATA, BASE + 32'(rcv));
      chk("s_last", 32'(ifc.S_LAST), 32'(rcv % 4 == 3));
      nlast += int'(ifc.S_LAST);
      rcv++;
    end
    ndone += int'(done);
    nwait += int'(busy && !tx_en);
    nsv += int'(ifc.S_VALID);
    @(posedge clk);
    #1;
    cyc++;
    if (hs_m) src++;
    ifc.M_VALID = pat == 0 ? 1'b1 : (cyc % 3 != 2);
    ifc.S_READY = pat == 0 ? 1'b1 : cyc[0];
  endtask
  task automatic clr();
    src = 0; rcv = 0; nlast = 0; ndone = 0; nwait = 0; nsv = 0;
  endtask
  task automatic go(int nblk);
    nblocks = 16'(nblk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(string tag);
    int n = 0;
    while (ndone == 0 && n < 2000) begin tick(); n++; end
    chk({tag, "_in_time"}, 32'(n < 2000), 1);
  endtask
  task automatic run_case(string tag, int nblk, logic v, logic [2:0] t, logic d0, int p,
                          int exp_words, logic exp_err, logic [1:0] exp_code, int exp_wait);
    clr();
    tv = v; tok = t; dat0 = d0; pat = p;
    go(nblk);
    wait_done(tag);
    repeat (3) tick();
    chk({tag, "_words"}, 32'(rcv), 32'(exp_words));
    chk({tag, "_lasts"}, 32'(nlast), 32'(exp_words / 4));
    chk({tag, "_done"}, 32'(ndone), 1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_code"}, 32'(errcode), 32'(exp_code));
    chk({tag, "_wait"}, 32'(nwait), 32'(exp_wait));
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  task automatic chk_quiet(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_code"}, 32'(errcode), 0);
    chk({tag, "_txen"}, 32'(tx_en), 0);
    chk({tag, "_svalid"}, 32'(ifc.S_VALID), 0);
    chk({tag, "_slast"}, 32'(ifc.S_LAST), 0);
    chk({tag, "_mready"}, 32'(ifc.M_READY), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    ifc.M_VALID = 1'b1;
    ifc.S_READY = 1'b1;
    repeat (2) tick();
    chk_quiet("reset");
    rst = 1'b0;
    tick();
    run_case("basic", 2, 1'b1, 3'b010, 1'b1, 0, 8, 1'b0, 2'b00, 4);
    run_case("gaps", 2, 1'b1, 3'b010, 1'b1, 1, 8, 1'b0, 2'b00, 4);
    run_case("crc", 3, 1'b1, 3'b101, 1'b1, 0, 4, 1'b1, 2'b01, 1);
    run_case("wrtok", 1, 1'b1, 3'b110, 1'b1, 0, 4, 1'b1, 2'b10, 1);
    run_case("badtok", 2, 1'b1, 3'b000, 1'b1, 0, 4, 1'b1, 2'b10, 1);
    run_case("stat_to", 2, 1'b0, 3'b010, 1'b1, 0, 4, 1'b1, 2'b11, 64);
    run_case("busy_to", 2, 1'b1, 3'b010, 1'b0, 0, 4, 1'b1, 2'b11, 256);
    run_case("three", 3, 1'b1, 3'b010, 1'b1, 1, 12, 1'b0, 2'b00, 6);
    clr();
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    chk("idle_abort_done", 32'(ndone), 0);
    chk("idle_abort_err", 32'(err), 0);
    chk("idle_abort_busy", 32'(busy), 0);
    clr();
    pat = 0;
    go(1);
    tick();
    abort = 1'b1;
    #1;
    chk("abort_svalid", 32'(ifc.S_VALID), 0);
    chk("abort_mready", 32'(ifc.M_READY), 0);
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_pulse", 32'(done), 1);
    chk("abort_err", 32'(err), 1);
    chk("abort_code", 32'(errcode), 3);
    repeat (3) tick();
    chk("abort_ndone", 32'(ndone), 1);
    chk("abort_words", 32'(rcv), 1);
    clr();
    tv = 1'b1; tok = 3'b010; dat0 = 1'b0;
    go(1);
    n = 0;
    while (nwait < 3 && n < 200) begin tick(); n++; end
    go(5);
    nblocks = 16'd1;
    ckstb = 1'b0; dat0 = 1'b1;
    repeat (5) tick();
    chk("ckstb_gate_done", 32'(ndone), 0);
    chk("ckstb_gate_busy", 32'(busy), 1);
    ckstb = 1'b1;
    wait_done("busy_start");
    repeat (3) tick();
    chk("busy_start_words", 32'(rcv), 4);
    chk("busy_start_ndone", 32'(ndone), 1);
    chk("busy_start_err", 32'(err), 0);
    clr();
    go(0);
    chk("zero_pulse", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    tick();
    chk("zero_pulse_end", 32'(done), 0);
    chk("zero_ndone", 32'(ndone), 1);
    chk("zero_nsv", 32'(nsv), 0);
    clr();
    tx_busy = 1'b1;
    go(1);
    repeat (20) tick();
    chk("drain_hold_wait", 32'(nwait), 0);
    chk("drain_hold_txen", 32'(tx_en), 1);
    chk("drain_hold_words", 32'(rcv), 4);
    tx_busy = 1'b0;
    wait_done("drain");
    chk("drain_err", 32'(err), 0);
    chk("drain_ndone", 32'(ndone), 1);
    clr();
    tv = 1'b0;
    go(1);
    n = 0;
    while (nwait < 5 && n < 200) begin tick(); n++; end
    rst = 1'b1;
    tick();
    chk_quiet("rst_status");
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_status_ndone", 32'(ndone), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/sdtx_sequencer.md
SDTX_SEQUENCER -- requirements
Module: sdtx_sequencer

Interface
REQ-001 Parameter LGBLK, default 9, log2 of block size in bytes; each block is 2^(LGBLK-2) 32-bit words.
REQ-002 Parameter LGTIMEOUT, default 20, width of the busy-wait timeout counter in i_ckstb ticks.
REQ-003 Parameter LGSTATUS, default 6, width of the CRC-status wait timeout counter in i_ckstb ticks.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  sole clock.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_start  in  1  single-cycle request to begin a multi-block write.
REQ-008 i_nblocks  in  16  number of blocks, latched on an accepted i_start.
REQ-009 i_abort  in  1  terminate the current transfer.
REQ-010 i_ckstb  in  1  card-clock strobe; gates all timeouts and i_dat0 sampling.
REQ-011 M_VALID/M_READY/M_DATA  in/out/in  1/1/32  word stream from memory.
REQ-012 S_VALID/S_READY/S_DATA/S_LAST  out/in/out/out  1/1/32/1  word stream to the tx framer.
REQ-013 o_tx_en  out  1  framer enable.
REQ-014 i_tx_busy  in  1  framer still serialising a frame or its CRC.
REQ-015 i_crcstat_valid/i_crcstat  in  1/3  card CRC-status token.
REQ-016 i_dat0  in  1  card busy line; low means busy.
REQ-017 o_busy/o_done/o_err/o_errcode  out  1/1/1/2  status; o_done is a one-cycle pulse.

Function
REQ-018 States SHALL be IDLE, DATA, DRAIN, STATUS and BUSY.
REQ-019 IDLE: on i_start, latch i_nblocks, clear o_err/o_errcode, and go to DATA; if i_nblocks==0, pulse o_done next cycle and stay in IDLE.
REQ-020 i_start SHALL be ignored outside IDLE.
REQ-021 DATA: S_VALID=M_VALID, M_READY=S_READY, S_DATA=M_DATA, combinationally, zero latency.
REQ-022 In all other states, S_VALID=0 and M_READY=0.
REQ-023 A word counter of width LGBLK-2 SHALL increment on each S_VALID&&S_READY and wrap to 0 after the last word of a block.
REQ-024 S_LAST SHALL be asserted on the final word of each block.
REQ-025 On acceptance of the final word, the state SHALL become DRAIN.
REQ-026 DRAIN: when i_tx_busy==0, go to STATUS and clear the status timer.
REQ-027 STATUS, token 3'b010 (accepted): go to BUSY.
REQ-028 STATUS, token 3'b101: error code 2'b01 (CRC).
REQ-029 STATUS, token 3'b110 or any other value: error code 2'b10 (write).
REQ-030 STATUS: 2^LGSTATUS i_ckstb ticks with no token gives error code 2'b11.
REQ-031 BUSY: i_dat0 is sampled only on i_ckstb.
REQ-032 BUSY: when i_dat0==1, decrement the block count; go to IDLE with an o_done pulse if it reaches 0, else go to DATA.
REQ-033 BUSY: 2^LGTIMEOUT-1 ticks with i_dat0 low gives error code 2'b11.
REQ-034 On any error: set o_err=1 and o_errcode, pulse o_done, return to IDLE; o_err/o_errcode hold until the next accepted i_start.
REQ-035 i_abort SHALL take priority over every other event in every non-IDLE state.
REQ-036 On i_abort: go to IDLE next cycle, drop S_VALID immediately (combinationally), pulse o_done, set o_err=1 and o_errcode=2'b11.
REQ-037 i_abort in IDLE SHALL have no effect.
REQ-038 o_busy SHALL be 1 in every state except IDLE.
REQ-039 o_tx_en SHALL be 1 in DATA and DRAIN only.
REQ-040 A CRC token and a timeout expiring in the same cycle SHALL resolve in favour of the token.
REQ-041 A token arriving outside STATUS SHALL be ignored.

Reset
REQ-042 i_reset SHALL force IDLE; clear the word, block and timer counters; and drive o_busy, o_done, o_err, o_errcode, o_tx_en, S_VALID, S_LAST and M_READY to 0.
REQ-043 Reset mid-transfer SHALL NOT produce an o_done pulse.

Structure
REQ-044 A shared package SHALL hold the state encoding, the error codes (NONE 00, CRC 01, WRITE 10, TIMEOUT 11) and the token constants 3'b010, 3'b101 and 3'b110.
REQ-045 One sub-module, sdtimeout, SHALL be used: a loadable down-counter with parameterised width, clocked by i_ckstb, with an expired flag; it is instanced for both the STATUS and BUSY timeouts.

Verification
REQ-046 LGBLK=4, i_nblocks=2, M_VALID always high, S_READY always high, tokens 010, i_dat0 high -> 8 words out, S_LAST on words 4 and 8, exactly one o_done, o_err=0.
REQ-047 S_READY toggling 50% and M_VALID gaps -> no word lost or duplicated, and S_LAST stays aligned with every 4th accepted word.
REQ-048 Token 3'b101 on block 1 of 3 -> o_err=1, o_errcode=01, second block never started.
REQ-049 No token for 64 ticks (LGSTATUS=6) -> o_errcode=11; i_dat0 held low for 2^LGTIMEOUT ticks -> o_errcode=11.
REQ-050 i_abort asserted mid-DATA -> S_VALID=0 the same cycle, IDLE next cycle, one o_done; i_start during BUSY -> ignored.
REQ-051 i_nblocks=0 -> o_done one cycle after i_start with no S_VALID; reset asserted in STATUS -> all outputs 0 and no o_done.
